// File: rtl/sample_chk_pkg.sv
// Shared types and helpers for the sample-path pattern checker:
// FSM state enum, LFSR tap masks and the expected-triple function.
package sample_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1, bit (e-1) set for each exponent e
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

  // Maximal-length tap masks for the widths we expect to see; anything
  // else falls back to the 16-bit mask truncated/extended to the width.
  function automatic logic [63:0] lfsr_taps(input int w);
    case (w)
      4:       return 64'h0000_0000_0000_000C;
      8:       return 64'h0000_0000_0000_00B8;
      16:      return {48'd0, LFSR_TAPS_16};
      32:      return 64'h0000_0000_8020_0003;
      default: return {48'd0, LFSR_TAPS_16};
    endcase
  endfunction

  // One Fibonacci step toward the MSB; callers zero-extend to 64 bits
  // and keep the low bits they care about.
  function automatic logic [63:0] lfsr_step(input logic [63:0] q,
                                            input logic [63:0] taps);
    return {q[62:0], ^(q & taps)};
  endfunction

  // What the registered-inverter path should report for input {a, b}:
  // {a_inv1, a_inv2, b_inv1}
  function automatic logic [2:0] exp_triple(input logic a, input logic b);
    return {a, ~a, ~b};
  endfunction

endpackage

// File: rtl/sample_chk_lfsr.sv
// Loadable Fibonacci LFSR with parallel output; holds SEED out of reset.
module sample_chk_lfsr
  import sample_chk_pkg::*;
#(
  parameter int unsigned  W    = 16,
  parameter logic [W-1:0] SEED = W'(16'hACE1),
  parameter logic [W-1:0] TAPS = W'(LFSR_TAPS_16)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         advance,
  output logic [W-1:0] q
);

  // Load has priority so a restart always begins from SEED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          q <= SEED;
    else if (load)    q <= SEED;
    else if (advance) q <= W'(lfsr_step(64'(q), 64'(TAPS)));
  end

endmodule

// File: rtl/sample_pattern_checker.sv
// In-situ equivalence checker for the two-bit registered-inverter sample
// path: drives a pseudo-random a/b pattern, compares the path's outputs one
// cycle later, and reports pass/fail, a saturating error count and
// (when SAMPLE_CHK_FIRST_ERR_EN is defined) the first failing vector.
module sample_pattern_checker
  import sample_chk_pkg::*;
#(
  parameter int unsigned       LFSR_W      = 16,
  parameter logic [LFSR_W-1:0] SEED        = LFSR_W'(16'hACE1),
  parameter int unsigned       NUM_VECTORS = 1024,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             pat_a,
  output logic             pat_b,
  input  logic             obs_a_inv1,
  input  logic             obs_a_inv2,
  input  logic             obs_b_inv1,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [2:0]       first_err_obs
);

  localparam int unsigned       RC_W    = $clog2(NUM_VECTORS + 1);
  localparam logic [RC_W-1:0]   RC_LAST = RC_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [LFSR_W-1:0] TAPS    = LFSR_W'(lfsr_taps(LFSR_W));

  state_t            state, state_nxt;
  logic [RC_W-1:0]   run_cnt;
  logic              run_last;
  logic              go;
  logic [LFSR_W-1:0] lfsr_q;
  logic [1:0]        ab_nxt;   // {b, a} of the next vector
  logic              exp_vld;
  logic [1:0]        exp_ab;   // {a, b} of the vector driven last cycle
  logic [2:0]        obs;
  logic              mism;

  assign run_last = (run_cnt == RC_LAST);
  assign go       = start && (state == IDLE || state == DONE);
  assign ab_nxt   = 2'(lfsr_step(64'(lfsr_q), 64'(TAPS)));
  assign obs      = {obs_a_inv1, obs_a_inv2, obs_b_inv1};
  assign mism     = exp_vld && (obs != exp_triple(exp_ab[1], exp_ab[0]));

  sample_chk_lfsr #(
    .W    (LFSR_W),
    .SEED (SEED),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (go),
    .advance (state == RUN),
    .q       (lfsr_q)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: RUN counts out NUM_VECTORS cycles, DRAIN is the last compare
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = RUN;
      RUN:     if (run_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (go) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state; pass only meaningful once done
  always_comb begin
    busy = (state == RUN) || (state == DRAIN);
    done = (state == DONE);
    pass = done && (err_count == '0);
  end

  // Pattern driver and run-length counter; first vector comes straight
  // from SEED so it appears right after the start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_a   <= 1'b0;
      pat_b   <= 1'b0;
      run_cnt <= '0;
    end else if (go) begin
      pat_a   <= SEED[0];
      pat_b   <= SEED[1];
      run_cnt <= '0;
    end else if (state == RUN) begin
      pat_a   <= run_last ? 1'b0 : ab_nxt[0];
      pat_b   <= run_last ? 1'b0 : ab_nxt[1];
      run_cnt <= run_cnt + RC_W'(1);
    end
  end

  // Expectation pipeline: mirror the path's single register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_vld <= 1'b0;
      exp_ab  <= 2'b00;
    end else begin
      exp_vld <= (state == RUN);
      exp_ab  <= {pat_a, pat_b};
    end
  end

  // Saturating mismatch counter, cleared on every start
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            err_count <= '0;
    else if (go)                        err_count <= '0;
    else if (mism && err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
  end

`ifdef SAMPLE_CHK_FIRST_ERR_EN
  logic [CNT_W-1:0] vec_idx;
  logic [CNT_W-1:0] exp_idx;
  logic [CNT_W-1:0] ferr_idx;
  logic [2:0]       ferr_obs;

  // Vector index travels with the registered vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_idx <= '0;
      exp_idx <= '0;
    end else begin
      exp_idx <= vec_idx;
      if (go)                 vec_idx <= '0;
      else if (state == RUN)  vec_idx <= vec_idx + CNT_W'(1);
    end
  end

  // Capture once per run: a zero error count means no mismatch seen yet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ferr_idx <= '0;
      ferr_obs <= '0;
    end else if (go) begin
      ferr_idx <= '0;
      ferr_obs <= '0;
    end else if (mism && err_count == '0) begin
      ferr_idx <= exp_idx;
      ferr_obs <= obs;
    end
  end

  assign first_err_idx = ferr_idx;
  assign first_err_obs = ferr_obs;
`else
  assign first_err_idx = '0;
  assign first_err_obs = '0;
`endif

endmodule

// File: tb/tb_sample_pattern_checker.sv
// Scoreboarded bench: an ideal/faulty registered-inverter path model feeds
// the checker; a reference model computes each run's expected results.
module tb_sample_pattern_checker;

  localparam int N  = 1024;
  localparam int NS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, start_s = 1'b0;
  int unsigned cyc = 0;
  int errors = 0, checks = 0;
  int mode = 0;

  logic pat_a, pat_b, obs_a_inv1, obs_a_inv2, obs_b_inv1, busy, done, pass;
  logic [15:0] err_count, first_err_idx;
  logic [2:0]  first_err_obs;
  logic s_pat_a, s_pat_b, s_o1, s_o2, s_o3, s_busy, s_done, s_pass;
  logic [2:0] s_err_count, s_first_err_idx, s_first_err_obs;
  logic ra = 1'b0, rb = 1'b0, rsa = 1'b0, rsb = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Path under test: 0 ideal, 1 b not inverted, 2 a_inv2 stuck 0, 3 all inverted
  function automatic logic [2:0] path_obs(input int m, input logic a, input logic b);
    case (m)
      1:       return {a, !a, b};
      2:       return {a, 1'b0, !b};
      3:       return {!a, a, b};
      default: return {a, !a, !b};
    endcase
  endfunction

  always @(posedge clk) begin
    ra <= pat_a; rb <= pat_b; rsa <= s_pat_a; rsb <= s_pat_b;
  end
  assign {obs_a_inv1, obs_a_inv2, obs_b_inv1} = path_obs(mode, ra, rb);
  assign {s_o1, s_o2, s_o3} = path_obs(3, rsa, rsb);

  sample_pattern_checker #(.LFSR_W(16), .SEED(16'hACE1), .NUM_VECTORS(N), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .pat_a(pat_a), .pat_b(pat_b),
    .obs_a_inv1(obs_a_inv1), .obs_a_inv2(obs_a_inv2), .obs_b_inv1(obs_b_inv1),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_obs(first_err_obs));

  sample_pattern_checker #(.LFSR_W(16), .SEED(16'hACE1), .NUM_VECTORS(NS), .CNT_W(3)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .pat_a(s_pat_a), .pat_b(s_pat_b),
    .obs_a_inv1(s_o1), .obs_a_inv2(s_o2), .obs_b_inv1(s_o3),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err_count),
    .first_err_idx(s_first_err_idx), .first_err_obs(s_first_err_obs));

  // Reference pattern: polynomial x^16+x^14+x^13+x^11+1, shift toward MSB
  bit va[N], vb[N];
  function automatic void build_vectors();
    logic [15:0] s = 16'hACE1;
    int ex[4] = '{16, 14, 13, 11};
    for (int k = 0; k < N; k++) begin
      logic fb = 1'b0;
      va[k] = s[0];
      vb[k] = s[1];
      foreach (ex[i]) fb = fb ^ s[ex[i]-1];
      s = {s[14:0], fb};
    end
  endfunction

  typedef struct {
    int unsigned err;
    bit          pass;
    int unsigned fidx;
    logic [2:0]  fobs;
    int unsigned done_at;
  } exp_t;
  exp_t sb[$];

  function automatic exp_t model(input int m, input int nv, input int unsigned cmax,
                                 input int unsigned done_at);
    exp_t e;
    bit seen = 0;
    e.err = 0; e.fidx = 0; e.fobs = 3'b000; e.done_at = done_at;
    for (int k = 0; k < nv; k++) begin
      logic [2:0] want = {va[k], !va[k], !vb[k]};
      logic [2:0] got  = path_obs(m, va[k], vb[k]);
      if (got != want) begin
        if (!seen) begin
          seen = 1;
`ifdef SAMPLE_CHK_FIRST_ERR_EN
          e.fidx = k % (cmax + 1);
          e.fobs = got;
`endif
        end
        if (e.err < cmax) e.err++;
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each rising done pops one expected run result
  initial begin : monitor
    bit dprev = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !dprev) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending run (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.done_at);
          chk("err_count", err_count, e.err);
          chk("pass", pass, e.pass);
          chk("first_err_idx", first_err_idx, e.fidx);
          chk("first_err_obs", first_err_obs, e.fobs);
        end
      end
      dprev = done;
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_pat_a"}, pat_a, 0);
    chk({tag, "_pat_b"}, pat_b, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_first_err_idx"}, first_err_idx, 0);
    chk({tag, "_first_err_obs"}, first_err_obs, 0);
  endtask

  // Run(s) on the main checker; runs>1 holds start through DONE
  task automatic run_main(input int m, input bit noise, input int runs);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    for (int r = 0; r < runs; r++) begin
      sb.push_back(model(m, N, 32'hFFFF, cyc + N + 2));
      @(negedge clk);
      if (r > 0) chk("restart_err_cleared", err_count, 0);
      for (int k = 0; k <= N; k++) begin
        chk("pat_a", pat_a, (k < N) ? va[k] : 1'b0);
        chk("pat_b", pat_b, (k < N) ? vb[k] : 1'b0);
        chk("busy", busy, 1);
        if (k == N) start = (r < runs - 1);
        else        start = noise ? ($urandom_range(0, 5) == 0) : 1'b0;
        @(negedge clk);
      end
      chk("done_after_run", done, 1);
    end
    start = 1'b0;
  endtask

  task automatic run_abort();
    @(negedge clk);
    mode  = 0;
    start = 1'b1;
    sb.push_back(model(0, N, 32'hFFFF, cyc + N + 2));
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    void'(sb.pop_back());
    check_reset("abort");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_small();
    exp_t e = model(3, NS, 7, 0);
    int unsigned e0;
    @(negedge clk);
    start_s = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start_s = 1'b0;
    for (int t = 0; t < NS + 20 && !s_done; t++) @(negedge clk);
    chk("small_done_cycle", cyc, e0 + NS + 1);
    chk("small_err_count", s_err_count, e.err);
    chk("small_pass", s_pass, 0);
    chk("small_first_err_idx", s_first_err_idx, e.fidx);
    chk("small_first_err_obs", s_first_err_obs, e.fobs);
  endtask

  initial begin : stim
    build_vectors();
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    run_main(0, 0, 1);   // ideal path
    run_main(1, 1, 1);   // b not inverted, start noise during run
    run_main(2, 1, 1);   // a_inv2 stuck at 0
    run_main(3, 0, 1);   // all outputs inverted
    run_small();         // saturation at 7
    run_abort();         // reset mid-run
    run_main(0, 0, 1);   // clean run after abort
    run_main(2, 0, 2);   // back-to-back via held start
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
